// File: rtl/dma_path_responder.sv
// Target-side DMA responder: grants a core request, decodes a 128-bit command header and either
// forwards write beats to the host or fetches host beats into a tagged, credit-limited return FIFO.
module dma_path_responder #(
    parameter int RD_FIFO_DEPTH = 8,
    parameter int BEAT_BYTES    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dma_req,
    output logic         dma_resp,
    input  logic         dma_write_valid,
    input  logic [127:0] dma_write_data,
    output logic         dma_write_ready,
    output logic         dma_read_valid,
    output logic [139:0] dma_read_data,
    input  logic         dma_read_ready,
    output logic         host_wr_valid,
    output logic [39:0]  host_wr_addr,
    output logic [127:0] host_wr_data,
    input  logic         host_wr_ready,
    output logic         host_rd_valid,
    output logic [39:0]  host_rd_addr,
    input  logic         host_rd_ready,
    input  logic         host_rdata_valid,
    input  logic [127:0] host_rdata,
    output logic         busy,
    output logic         err_opcode
);
    localparam int AW = $clog2(RD_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0]    OP_READ    = 8'h01;
    localparam logic [7:0]    OP_WRITE   = 8'h03;
    localparam logic [39:0]   BEAT_STEP  = 40'(BEAT_BYTES);
    localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(RD_FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(RD_FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_WR   = 3'd2,
        S_RD   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [11:0]   local_addr_q, local_addr_d;
    logic [39:0]   host_addr_q, host_addr_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   beat_q, beat_d;
    logic [15:0]   ret_q, ret_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          err_q, err_d;
    logic          dma_resp_q, dma_resp_d;
    logic [139:0]  fifo_mem_q [RD_FIFO_DEPTH];

    logic          fifo_nempty_s;
    logic          credit_ok_s;
    logic          rd_req_s;
    logic          rd_fire_s;
    logic          push_s;
    logic          pop_s;
    logic [39:0]   beat_addr_s;
    logic [11:0]   tag_s;
    logic          unused_hdr_s;

    // Beat i (write) and issue index (read) share beat_q; the two states never overlap.
    assign beat_addr_s   = host_addr_q + ({24'd0, beat_q} * BEAT_STEP);
    assign tag_s         = local_addr_q + ret_q[11:0];
    assign fifo_nempty_s = (fifo_cnt_q != {CW{1'b0}});
    assign credit_ok_s   = (({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < CREDIT_MAX);
    assign rd_req_s      = (state_q == S_RD) && (beat_q < len_q) && credit_ok_s;
    assign rd_fire_s     = rd_req_s && host_rd_ready;
    assign push_s        = host_rdata_valid && (state_q == S_RD);
    assign pop_s         = fifo_nempty_s && dma_read_ready;
    assign unused_hdr_s  = ^{dma_write_data[127:80], dma_write_data[15:12]};

    assign dma_resp       = dma_resp_q;
    assign err_opcode     = err_q;
    assign busy           = (state_q != S_IDLE) || fifo_nempty_s;
    assign dma_read_valid = fifo_nempty_s;
    assign dma_read_data  = fifo_nempty_s ? fifo_mem_q[rd_ptr_q] : 140'd0;

    // Transfer FSM: next state, header capture and the stream/host handshakes.
    always_comb begin
        state_d         = state_q;
        local_addr_d    = local_addr_q;
        host_addr_d     = host_addr_q;
        len_d           = len_q;
        beat_d          = beat_q;
        ret_d           = ret_q;
        err_d           = err_q;
        dma_resp_d      = 1'b0;
        dma_write_ready = 1'b0;
        host_wr_valid   = 1'b0;
        host_wr_addr    = 40'd0;
        host_wr_data    = 128'd0;
        host_rd_valid   = 1'b0;
        host_rd_addr    = 40'd0;
        case (state_q)
            S_IDLE: begin
                if (dma_req && !fifo_nempty_s) begin
                    dma_resp_d = 1'b1;
                    state_d    = S_HDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                dma_write_ready = 1'b1;
                if (dma_write_valid) begin
                    local_addr_d = dma_write_data[11:0];
                    host_addr_d  = dma_write_data[55:16];
                    len_d        = dma_write_data[71:56];
                    beat_d       = 16'd0;
                    ret_d        = 16'd0;
                    case (dma_write_data[79:72])
                        OP_WRITE: state_d = S_WR;
                        OP_READ:  state_d = S_RD;
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end else begin
                    state_d = S_HDR;
                end
            end
            S_WR: begin
                if (len_q == 16'd0) begin
                    state_d = S_DONE;
                end else begin
                    host_wr_valid   = dma_write_valid;
                    dma_write_ready = host_wr_ready;
                    host_wr_addr    = beat_addr_s;
                    host_wr_data    = dma_write_data;
                    if (dma_write_valid && host_wr_ready) begin
                        beat_d = beat_q + 16'd1;
                        if (beat_q == (len_q - 16'd1)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_WR;
                        end
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_RD: begin
                host_rd_valid = rd_req_s;
                host_rd_addr  = beat_addr_s;
                if (rd_fire_s) begin
                    beat_d = beat_q + 16'd1;
                end else begin
                    beat_d = beat_q;
                end
                if (push_s) begin
                    ret_d = ret_q + 16'd1;
                end else begin
                    ret_d = ret_q;
                end
                if ((beat_q == len_q) && (ret_q == len_q)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outstanding-read counter and FIFO pointer/occupancy bookkeeping.
    always_comb begin
        outst_d    = outst_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({rd_fire_s, push_s})
            2'b10:   outst_d = outst_q + CNT_ONE;
            2'b01:   outst_d = outst_q - CNT_ONE;
            default: outst_d = outst_q;
        endcase
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            local_addr_q <= 12'd0;
            host_addr_q  <= 40'd0;
            len_q        <= 16'd0;
            beat_q       <= 16'd0;
            ret_q        <= 16'd0;
            outst_q      <= {CW{1'b0}};
            fifo_cnt_q   <= {CW{1'b0}};
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            err_q        <= 1'b0;
            dma_resp_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            local_addr_q <= local_addr_d;
            host_addr_q  <= host_addr_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            ret_q        <= ret_d;
            outst_q      <= outst_d;
            fifo_cnt_q   <= fifo_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            err_q        <= err_d;
            dma_resp_q   <= dma_resp_d;
        end
    end

    // Return FIFO storage; contents are masked by the occupancy count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= {tag_s, host_rdata};
        end
    end

    // The credit rule must keep a push from ever landing on a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_s && !pop_s && (fifo_cnt_q == CNT_FULL)));

endmodule

// File: tb/tb_dma_path_responder.sv
// Scoreboard bench for dma_path_responder: directed transfers push expected host writes, host read
// requests and read returns into queues; a negedge monitor pops and compares each DUT handshake.
module tb_dma_path_responder;
    logic         clk = 1'b0;
    logic         rst;
    logic         dma_req, dma_resp;
    logic         dma_write_valid, dma_write_ready;
    logic [127:0] dma_write_data;
    logic         dma_read_valid, dma_read_ready;
    logic [139:0] dma_read_data;
    logic         host_wr_valid, host_wr_ready;
    logic [39:0]  host_wr_addr;
    logic [127:0] host_wr_data;
    logic         host_rd_valid, host_rd_ready;
    logic [39:0]  host_rd_addr;
    logic         host_rdata_valid;
    logic [127:0] host_rdata;
    logic         busy, err_opcode;

    int n_checks = 0;
    int n_fail   = 0;
    int rdreq_seen = 0;
    int ret_seen   = 0;
    logic [167:0] exp_wr[$];
    logic [39:0]  exp_rdreq[$];
    logic [139:0] exp_ret[$];
    logic [39:0]  pend[$];

    dma_path_responder #(.RD_FIFO_DEPTH(8), .BEAT_BYTES(16)) dut (
        .clk(clk), .rst(rst), .dma_req(dma_req), .dma_resp(dma_resp),
        .dma_write_valid(dma_write_valid), .dma_write_data(dma_write_data),
        .dma_write_ready(dma_write_ready), .dma_read_valid(dma_read_valid),
        .dma_read_data(dma_read_data), .dma_read_ready(dma_read_ready),
        .host_wr_valid(host_wr_valid), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_wr_ready(host_wr_ready), .host_rd_valid(host_rd_valid), .host_rd_addr(host_rd_addr),
        .host_rd_ready(host_rd_ready), .host_rdata_valid(host_rdata_valid),
        .host_rdata(host_rdata), .busy(busy), .err_opcode(err_opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] data_of(input logic [39:0] a);
        return {24'hDA7A00, a, 24'hC0FFEE, a};
    endfunction

    function automatic logic [127:0] hdr(input logic [7:0] op, input logic [15:0] len,
                                         input logic [39:0] ha, input logic [11:0] la);
        return {48'd0, op, len, ha, 4'h0, la};
    endfunction

    task automatic check(input string name, input logic [167:0] act, input logic [167:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every DUT handshake is compared against the head of its expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (host_wr_valid && host_wr_ready) begin
                if (exp_wr.size() == 0) fail_now("host_wr_extra");
                else check("host_wr", {host_wr_addr, host_wr_data}, exp_wr.pop_front());
            end
            if (host_rd_valid && host_rd_ready) begin
                rdreq_seen++;
                pend.push_back(host_rd_addr);
                if (exp_rdreq.size() == 0) fail_now("host_rd_extra");
                else check("host_rd_addr", 168'(host_rd_addr), 168'(exp_rdreq.pop_front()));
            end
            if (dma_read_valid && dma_read_ready) begin
                ret_seen++;
                if (exp_ret.size() == 0) fail_now("dma_read_extra");
                else check("dma_read", 168'(dma_read_data), 168'(exp_ret.pop_front()));
            end
        end
    end

    // Host memory model: returns one beat per cycle, in order, for each accepted read request.
    initial begin
        host_rdata_valid = 1'b0;
        host_rdata       = 128'd0;
        forever begin
            tick();
            if (rst) begin
                pend.delete();
                host_rdata_valid = 1'b0;
            end else if (pend.size() > 0) begin
                host_rdata_valid = 1'b1;
                host_rdata       = data_of(pend.pop_front());
            end else begin
                host_rdata_valid = 1'b0;
                host_rdata       = 128'd0;
            end
        end
    end

    task automatic grant(input string name);
        bit got = 1'b0;
        dma_req = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (dma_resp) begin
                got = 1'b1;
                break;
            end
        end
        dma_req = 1'b0;
        check(name, 168'(got), 168'(1));
        tick();
        check({name, "_pulse"}, 168'(dma_resp), 168'(0));
    endtask

    task automatic send_beat(input logic [127:0] d, input string name);
        bit ok = 1'b0;
        dma_write_valid = 1'b1;
        dma_write_data  = d;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (dma_write_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        dma_write_valid = 1'b0;
        check(name, 168'(ok), 168'(1));
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(name, 168'(ok), 168'(1));
    endtask

    task automatic push_read(input logic [39:0] ha, input logic [11:0] la, input int len);
        for (int i = 0; i < len; i++) begin
            logic [39:0] a;
            a = ha + 40'(16 * i);
            exp_rdreq.push_back(a);
            exp_ret.push_back({la + 12'(i), data_of(a)});
        end
    endtask

    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int rq0;
        int k;
        bit done;
        rst = 1'b1; dma_req = 1'b0; dma_write_valid = 1'b0; dma_write_data = 128'd0;
        dma_read_ready = 1'b1; host_wr_ready = 1'b1; host_rd_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset_outputs", 168'({dma_resp, dma_write_ready, dma_read_valid, host_wr_valid,
              host_rd_valid, busy, err_opcode}), 168'(0));

        // 1: three-beat write
        for (int i = 0; i < 3; i++)
            exp_wr.push_back({40'h10_0000_0000 + 40'(16 * i), {96'hFEED_FACE_0000_0000_0000_0000, 32'(i)}});
        grant("t1_grant");
        send_beat(hdr(8'h03, 16'd3, 40'h10_0000_0000, 12'h010), "t1_hdr");
        for (int i = 0; i < 3; i++)
            send_beat({96'hFEED_FACE_0000_0000_0000_0000, 32'(i)}, "t1_beat");
        check("t1_busy_done", 168'(busy), 168'(1));
        tick();
        check("t1_busy_fall", 168'(busy), 168'(0));
        check("t1_wr_drained", 168'(exp_wr.size()), 168'(0));

        // 2: write with host backpressure 1,0,0,1
        for (int i = 0; i < 4; i++)
            exp_wr.push_back({40'h20_0000_0040 + 40'(16 * i), {96'h0, 32'hB000_0000 + 32'(i)}});
        grant("t2_grant");
        send_beat(hdr(8'h03, 16'd4, 40'h20_0000_0040, 12'h000), "t2_hdr");
        k = 0;
        for (int b = 0; b < 4; b++) begin
            dma_write_valid = 1'b1;
            dma_write_data  = {96'h0, 32'hB000_0000 + 32'(b)};
            done = 1'b0;
            for (int c = 0; c < 20 && !done; c++) begin
                host_wr_ready = pat[k % 4];
                k++;
                #1;
                check("t2_ready_mirror", 168'(dma_write_ready), 168'(host_wr_ready));
                done = host_wr_ready;
                tick();
            end
        end
        dma_write_valid = 1'b0;
        host_wr_ready   = 1'b1;
        wait_idle("t2_idle");
        check("t2_wr_drained", 168'(exp_wr.size()), 168'(0));

        // 3: 20-beat read with a stalled reader, then drain
        push_read(40'h30_0000_0000, 12'h100, 20);
        dma_read_ready = 1'b0;
        grant("t3_grant");
        rq0 = rdreq_seen;
        send_beat(hdr(8'h01, 16'd20, 40'h30_0000_0000, 12'h100), "t3_hdr");
        for (int c = 0; c < 50; c++) tick();
        check("t3_issued_limit", 168'(rdreq_seen - rq0), 168'(8));
        check("t3_fifo_valid", 168'(dma_read_valid), 168'(1));
        dma_read_ready = 1'b1;
        wait_idle("t3_idle");
        check("t3_issued_total", 168'(rdreq_seen - rq0), 168'(20));
        check("t3_ret_drained", 168'(exp_ret.size()), 168'(0));

        // 4: local tag and host address wrap
        exp_rdreq.push_back(40'hFF_FFFF_FFE0); exp_ret.push_back({12'hFFE, data_of(40'hFF_FFFF_FFE0)});
        exp_rdreq.push_back(40'hFF_FFFF_FFF0); exp_ret.push_back({12'hFFF, data_of(40'hFF_FFFF_FFF0)});
        exp_rdreq.push_back(40'h00_0000_0000); exp_ret.push_back({12'h000, data_of(40'h00_0000_0000)});
        exp_rdreq.push_back(40'h00_0000_0010); exp_ret.push_back({12'h001, data_of(40'h00_0000_0010)});
        grant("t4_grant");
        send_beat(hdr(8'h01, 16'd4, 40'hFF_FFFF_FFE0, 12'hFFE), "t4_hdr");
        wait_idle("t4_idle");
        check("t4_ret_drained", 168'(exp_ret.size()), 168'(0));

        // 5: bad opcode (sticky error), then zero-length write and read
        grant("t5_grant_bad");
        send_beat(hdr(8'h07, 16'd2, 40'h12_3456_7890, 12'h055), "t5_hdr_bad");
        wait_idle("t5_idle_bad");
        check("t5_err_set", 168'(err_opcode), 168'(1));
        grant("t5_grant_w0");
        send_beat(hdr(8'h03, 16'd0, 40'h01_0000_0000, 12'h000), "t5_hdr_w0");
        wait_idle("t5_idle_w0");
        grant("t5_grant_r0");
        rq0 = rdreq_seen;
        send_beat(hdr(8'h01, 16'd0, 40'h01_0000_0000, 12'h000), "t5_hdr_r0");
        wait_idle("t5_idle_r0");
        check("t5_no_reads", 168'(rdreq_seen - rq0), 168'(0));
        check("t5_err_sticky", 168'(err_opcode), 168'(1));

        // 6: reset mid-read, then a fresh read
        push_read(40'h40_0000_0000, 12'h200, 10);
        grant("t6_grant");
        rq0 = ret_seen;
        send_beat(hdr(8'h01, 16'd10, 40'h40_0000_0000, 12'h200), "t6_hdr");
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (ret_seen - rq0 >= 5) done = 1'b1;
            else tick();
        end
        check("t6_five_returned", 168'(done), 168'(1));
        check("t6_busy_before", 168'(busy), 168'(1));
        rst = 1'b1;
        exp_rdreq.delete(); exp_ret.delete(); pend.delete();
        tick();
        check("t6_rst_outputs", 168'({dma_resp, dma_write_ready, dma_read_valid, host_wr_valid,
              host_rd_valid, busy, err_opcode}), 168'(0));
        check("t6_rst_rdata", 168'(dma_read_data), 168'(0));
        check("t6_rst_rdaddr", 168'(host_rd_addr), 168'(0));
        rst = 1'b0;
        tick();
        push_read(40'h50_0000_0100, 12'h007, 3);
        grant("t6_grant2");
        send_beat(hdr(8'h01, 16'd3, 40'h50_0000_0100, 12'h007), "t6_hdr2");
        wait_idle("t6_idle2");

        check("final_wr_q", 168'(exp_wr.size()), 168'(0));
        check("final_rdreq_q", 168'(exp_rdreq.size()), 168'(0));
        check("final_ret_q", 168'(exp_ret.size()), 168'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog against a hung handshake.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dma_path_responder.md
Name: dma_path_responder

Overview:
Target-side end of the core DMA request/stream protocol. Grants a core request and accepts one 128-bit command header on the write stream, then decodes it. A host-write command (opcode 0x03) forwards data beats to the host write port. A host-read command (opcode 0x01) issues host beat reads and returns tagged beats on the 140-bit read stream through a credit-limited FIFO. It sits between the per-core load/store controllers and the host memory interface.

Parameters:
RD_FIFO_DEPTH, 8, read-return FIFO entries (power of 2, >=2); also the maximum number of outstanding host reads.
BEAT_BYTES, 16, host address increment per beat.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dma_req  in  1  core transfer request (level, held until dma_resp)
dma_resp  out  1  one-cycle grant pulse
dma_write_valid  in  1  write-stream beat valid (header, then data)
dma_write_data  in  128  write-stream beat
dma_write_ready  out  1  write-stream ready
dma_read_valid  out  1  read-return beat valid
dma_read_data  out  140  {local_addr[11:0], data[127:0]}
dma_read_ready  in  1  read-return ready
host_wr_valid  out  1  host write beat valid
host_wr_addr  out  40  host write byte address
host_wr_data  out  128  host write data
host_wr_ready  in  1  host write accept
host_rd_valid  out  1  host read request valid
host_rd_addr  out  40  host read byte address
host_rd_ready  in  1  host read request accept
host_rdata_valid  in  1  host read data return, in order, no backpressure
host_rdata  in  128  host read data
busy  out  1  high whenever state != IDLE or the FIFO is not empty
err_opcode  out  1  sticky: header carried an unknown opcode

Behaviour:
- rst is synchronous: all outputs 0, FSM to IDLE, counters 0, FIFO emptied, err_opcode cleared. A reset mid-transfer abandons the transfer. The host side shares rst, so no stale read data arrives afterwards.
- Handshakes: a beat transfers on valid&&ready. Both stream inputs qualify valid with ready.
- Header fields: [11:0] local_addr, [15:12] ignored, [55:16] host_addr, [71:56] len (beats), [79:72] opcode, [127:80] ignored.
- FSM:
  - IDLE: when dma_req is high and the FIFO is empty, pulse dma_resp for 1 cycle and go to HDR. dma_req arriving while the FIFO is non-empty waits.
  - HDR: dma_write_ready=1. On a beat, latch the fields and reset beat count i=0. Opcode 0x03 -> WR. Opcode 0x01 -> RD. Any other opcode -> set err_opcode and go to DONE; no host traffic.
  - WR: host_wr_valid=dma_write_valid, dma_write_ready=host_wr_ready (combinational pass-through, zero latency). host_wr_addr=host_addr+i*BEAT_BYTES, host_wr_data=dma_write_data. i increments per accepted beat. When len==0, or on the beat where i reaches len-1, go to DONE. dma_write_ready=0 in all states except HDR and WR.
  - RD: host_rd_valid is high while issued<len and (outstanding+fifo_count)<RD_FIFO_DEPTH. host_rd_addr=host_addr+issued*BEAT_BYTES. When len==0, go to DONE immediately. Go to DONE once issued==len and all returns have been written into the FIFO.
  - DONE: 1 cycle, then IDLE.
- Read return: each host_rdata_valid pushes {local_addr+ret_idx (12-bit wrap), host_rdata} into the FIFO.
  - The credit rule guarantees the FIFO never overflows. Overflow is a design error; assert it in simulation.
  - dma_read_valid = FIFO not empty; dma_read_data = FIFO head (first-word-fall-through).
  - A push and a pop in the same cycle leave the count unchanged.
- Address arithmetic: host address is 40-bit modular (wraps past 2^40-1); local tag is 12-bit modular; len is unsigned 16-bit, maximum 65535 beats.
- Back-to-back: a new dma_req is granted no earlier than the cycle after DONE and only with an empty FIFO. Minimum gap from DONE to the next dma_resp is 1 cycle.

Test Plan:
1. Write: len=3, host_addr=0x10_0000_0000, local 0x010, host_wr_ready=1 -> exactly 3 host writes at 0x1000000000/0x1000000010/0x1000000020 with data matching the stream; busy falls 2 cycles after the last beat.
2. Write backpressure: host_wr_ready toggles 1,0,0,1 -> dma_write_ready mirrors it; no beat lost or duplicated; 4-beat count honored.
3. Read: len=20, RD_FIFO_DEPTH=8, dma_read_ready=0 for 50 cycles -> at most 8 host_rd issued; FIFO full, no overflow. Then ready=1 -> 20 beats in order, tags local+0..19, data intact.
4. Tag wrap: local_addr=0xFFE, len=4 -> tags 0xFFE,0xFFF,0x000,0x001. Host address crossing 0xFF_FFFF_FFF0 wraps to 0.
5. Error and len=0: opcode 0x07 -> err_opcode=1 sticky, no host traffic, next request still served. Write/read with len=0 -> header consumed, no host traffic, IDLE after DONE.
6. Reset mid-read after 5 of 10 beats returned -> next cycle all outputs 0, FIFO empty, err cleared; a new request completes normally.
